// File: rtl/ttl_half_duplex_phy.sv
// 8N1 UART bit engine with single-wire half-duplex direction control.
// Serialises bytes from a valid/ready port and strobes received bytes out.
module ttl_half_duplex_phy #(
  parameter int CLK_FREQ_HZ = 72_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int GUARD_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  input  logic       half_duplex_en,
  input  logic       serial_i,
  output logic       serial_o,
  output logic       serial_oe
);

  localparam int CPB = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);
  localparam int GW = (GUARD_BITS > 1) ? $clog2(GUARD_BITS) : 1;
  localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD_BITS > 0) ? GUARD_BITS - 1 : 0);

  generate
    if (CPB < 8) begin : g_cpb_check
      $error("ttl_half_duplex_phy: CLK_FREQ_HZ/BAUD_RATE must be at least 8");
    end
  endgenerate

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_GUARD} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;

  tx_state_e         tx_state_q;
  logic [CW-1:0]     tx_cnt_q;
  logic [2:0]        tx_bit_q;
  logic [7:0]        tx_shift_q;
  logic [GW-1:0]     guard_q;
  logic              serial_o_q;
  logic              serial_oe_q;

  rx_state_e         rx_state_q;
  logic [CW-1:0]     rx_cnt_q;
  logic [2:0]        rx_bit_q;
  logic [7:0]        rx_shift_q;
  logic [7:0]        rx_data_q;
  logic              rx_valid_q;
  logic              frame_err_q;
  logic              rx_meta_q;
  logic              rx_s_q;
  logic              rx_prev_q;

  logic              hd_q;
  logic              hd_d;
  logic              tx_idle;
  logic              rx_idle;
  logic              tx_fire;
  logic              rx_block;
  logic              rx_fall;

  assign tx_idle  = (tx_state_q == TX_IDLE);
  assign rx_idle  = (rx_state_q == RX_IDLE);
  // On a shared wire TX must not start while a frame is arriving.
  assign tx_ready = tx_idle && !(hd_q && !rx_idle);
  assign tx_fire  = tx_valid && tx_ready;
  assign hd_d     = (tx_idle && rx_idle) ? half_duplex_en : hd_q;
  assign rx_block = hd_q && (!tx_idle || tx_fire);
  assign rx_fall  = rx_prev_q && !rx_s_q;

  assign serial_o  = serial_o_q;
  assign serial_oe = serial_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd_q <= 1'b0;
    end else begin
      hd_q <= hd_d;
    end
  end

  // Back-to-back frames are separated only by the handshake cycle,
  // which the far end sees as a marginally long stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      guard_q     <= '0;
      serial_o_q  <= 1'b1;
      serial_oe_q <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          serial_o_q  <= 1'b1;
          serial_oe_q <= !hd_d;
          if (tx_fire) begin
            tx_shift_q  <= tx_data;
            tx_cnt_q    <= '0;
            serial_o_q  <= 1'b0;
            serial_oe_q <= 1'b1;
            tx_state_q  <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            serial_o_q <= tx_shift_q[0];
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              serial_o_q <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_bit_q   <= tx_bit_q + 1'b1;
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              serial_o_q <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_q    <= '0;
            guard_q     <= '0;
            serial_oe_q <= !hd_q;
            if (hd_q && (GUARD_BITS > 0)) begin
              tx_state_q <= TX_GUARD;
            end else begin
              tx_state_q <= TX_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_GUARD: begin
          serial_oe_q <= 1'b0;
          if (tx_cnt_q == CNT_LAST) begin
            tx_cnt_q <= '0;
            if (guard_q == GUARD_LAST) begin
              tx_state_q <= TX_IDLE;
            end else begin
              guard_q <= guard_q + 1'b1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= serial_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (rx_block) begin
        // Our own transmission echoes back on a shared wire; ignore it.
        rx_state_q <= RX_IDLE;
      end else begin
        case (rx_state_q)
          RX_IDLE: begin
            if (rx_fall) begin
              rx_cnt_q   <= '0;
              rx_state_q <= RX_START;
            end
          end
          RX_START: begin
            if (rx_cnt_q == CNT_HALF) begin
              rx_cnt_q   <= '0;
              rx_bit_q   <= '0;
              rx_state_q <= rx_s_q ? RX_IDLE : RX_DATA;
            end else begin
              rx_cnt_q <= rx_cnt_q + 1'b1;
            end
          end
          RX_DATA: begin
            if (rx_cnt_q == CNT_LAST) begin
              rx_cnt_q   <= '0;
              rx_shift_q <= {rx_s_q, rx_shift_q[7:1]};
              if (rx_bit_q == 3'd7) begin
                rx_state_q <= RX_STOP;
              end else begin
                rx_bit_q <= rx_bit_q + 1'b1;
              end
            end else begin
              rx_cnt_q <= rx_cnt_q + 1'b1;
            end
          end
          RX_STOP: begin
            if (rx_cnt_q == CNT_LAST) begin
              rx_cnt_q <= '0;
              if (rx_s_q) begin
                rx_data_q  <= rx_shift_q;
                rx_valid_q <= 1'b1;
                rx_state_q <= RX_IDLE;
              end else begin
                frame_err_q <= 1'b1;
                rx_state_q  <= RX_WAIT_HIGH;
              end
            end else begin
              rx_cnt_q <= rx_cnt_q + 1'b1;
            end
          end
          RX_WAIT_HIGH: begin
            if (rx_s_q) begin
              rx_state_q <= RX_IDLE;
            end
          end
          default: rx_state_q <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ttl_half_duplex_phy.sv
// Directed bench for ttl_half_duplex_phy at CPB=10 (1 MHz clock, 100 kbaud).
`timescale 1ns/1ps
module tb_ttl_half_duplex_phy;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       half_duplex_en = 1'b0;
  logic       ser_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       serial_i;
  logic       serial_o;
  logic       serial_oe;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int rxv_cnt = 0;
  int ferr_cnt = 0;
  int rxv_cyc = 0;
  logic [7:0] rxv_data = 8'h00;

  // Line with a pull-up: in loopback the bus carries our own drive.
  assign serial_i = loop_en ? (serial_oe ? serial_o : 1'b1) : ser_drv;

  ttl_half_duplex_phy #(
    .CLK_FREQ_HZ(1_000_000),
    .BAUD_RATE  (100_000),
    .GUARD_BITS (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .frame_err     (frame_err),
    .half_duplex_en(half_duplex_en),
    .serial_i      (serial_i),
    .serial_o      (serial_o),
    .serial_oe     (serial_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      rxv_cnt  = rxv_cnt + 1;
      rxv_cyc  = cyc;
      rxv_data = rx_data;
    end
    if (frame_err) ferr_cnt = ferr_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return d[idx-1];
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int extra_low);
    for (int b = 0; b < 10; b++) begin
      ser_drv = (b == 9) ? stop_lvl : frame_bit(d, b);
      repeat (10) tick();
    end
    if (extra_low > 0) begin
      ser_drv = 1'b0;
      repeat (extra_low) tick();
    end
    ser_drv = 1'b1;
  endtask

  task automatic test_reset();
    checks++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready got %b exp 1", tx_ready); else passed++;
    checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b exp 0", rx_valid); else passed++;
    checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b exp 0", frame_err); else passed++;
    checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %02h exp 00", rx_data); else passed++;
    checks++; if (serial_o !== 1'b1) $display("FAIL reset_serial_o got %b exp 1", serial_o); else passed++;
    checks++; if (serial_oe !== 1'b0) $display("FAIL reset_serial_oe got %b exp 0", serial_oe); else passed++;
    rst_n = 1'b1;
    tick();
    checks++; if (serial_oe !== 1'b1) $display("FAIL fd_oe_after_reset got %b exp 1", serial_oe); else passed++;
    checks++; if (tx_ready !== 1'b1) $display("FAIL ready_after_reset got %b exp 1", tx_ready); else passed++;
    $display("reset released");
  endtask

  task automatic test_tx_fd(input logic [7:0] d);
    tx_data = d; tx_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 1; i <= 101; i++) begin
      if (i <= 100) begin
        checks++; if (serial_o !== frame_bit(d, (i-1)/10))
          $display("FAIL tx_fd_bit cycle %0d got %b exp %b", i, serial_o, frame_bit(d, (i-1)/10)); else passed++;
        checks++; if (serial_oe !== 1'b1) $display("FAIL tx_fd_oe cycle %0d got %b exp 1", i, serial_oe); else passed++;
        checks++; if (tx_ready !== 1'b0) $display("FAIL tx_fd_busy cycle %0d got %b exp 0", i, tx_ready); else passed++;
        tick();
      end else begin
        checks++; if (tx_ready !== 1'b1) $display("FAIL tx_fd_ready_101 got %b exp 1", tx_ready); else passed++;
      end
    end
    $display("tx 0x%02h full duplex done", d);
  endtask

  task automatic test_rx_good(input logic [7:0] d);
    int base, fbase, start, lat;
    base = rxv_cnt; fbase = ferr_cnt; start = cyc;
    send_frame(d, 1'b1, 0);
    repeat (5) tick();
    lat = rxv_cyc - start;
    checks++; if (rxv_cnt - base !== 1) $display("FAIL rx_good_count got %0d exp 1", rxv_cnt - base); else passed++;
    checks++; if (rxv_data !== d) $display("FAIL rx_good_data got %02h exp %02h", rxv_data, d); else passed++;
    checks++; if (lat < 96 || lat > 98) $display("FAIL rx_latency got %0d exp 96..98", lat); else passed++;
    checks++; if (ferr_cnt - fbase !== 0) $display("FAIL rx_good_ferr got %0d exp 0", ferr_cnt - fbase); else passed++;
    $display("rx 0x%02h received latency %0d", d, lat);
  endtask

  task automatic test_frame_err();
    int base, fbase;
    base = rxv_cnt; fbase = ferr_cnt;
    send_frame(8'h55, 1'b0, 20);
    repeat (20) tick();
    checks++; if (ferr_cnt - fbase !== 1) $display("FAIL ferr_count got %0d exp 1", ferr_cnt - fbase); else passed++;
    checks++; if (rxv_cnt - base !== 0) $display("FAIL ferr_no_valid got %0d exp 0", rxv_cnt - base); else passed++;
    checks++; if (rx_data !== 8'h3C) $display("FAIL ferr_data_held got %02h exp 3c", rx_data); else passed++;
    $display("rx 0x55 with break: frame error seen");
    base = rxv_cnt; fbase = ferr_cnt;
    send_frame(8'h12, 1'b1, 0);
    repeat (5) tick();
    checks++; if (rxv_cnt - base !== 1) $display("FAIL after_ferr_count got %0d exp 1", rxv_cnt - base); else passed++;
    checks++; if (rx_data !== 8'h12) $display("FAIL after_ferr_data got %02h exp 12", rx_data); else passed++;
    checks++; if (ferr_cnt - fbase !== 0) $display("FAIL after_ferr_ferr got %0d exp 0", ferr_cnt - fbase); else passed++;
    $display("rx 0x12 after break received");
  endtask

  task automatic test_glitch();
    int base, fbase;
    base = rxv_cnt; fbase = ferr_cnt;
    ser_drv = 1'b0;
    repeat (3) tick();
    ser_drv = 1'b1;
    repeat (30) tick();
    checks++; if (rxv_cnt - base !== 0) $display("FAIL glitch_valid got %0d exp 0", rxv_cnt - base); else passed++;
    checks++; if (ferr_cnt - fbase !== 0) $display("FAIL glitch_ferr got %0d exp 0", ferr_cnt - fbase); else passed++;
    send_frame(8'h5A, 1'b1, 0);
    repeat (5) tick();
    checks++; if (rxv_cnt - base !== 1) $display("FAIL post_glitch_count got %0d exp 1", rxv_cnt - base); else passed++;
    checks++; if (rx_data !== 8'h5A) $display("FAIL post_glitch_data got %02h exp 5a", rx_data); else passed++;
    $display("glitch rejected, rx 0x5a received");
  endtask

  task automatic test_hd_tx(input logic [7:0] d);
    int base, fbase, oe_cycles;
    logic exp_oe, exp_rdy, exp_o;
    half_duplex_en = 1'b1; loop_en = 1'b1;
    repeat (3) tick();
    checks++; if (serial_oe !== 1'b0) $display("FAIL hd_idle_oe got %b exp 0", serial_oe); else passed++;
    base = rxv_cnt; fbase = ferr_cnt; oe_cycles = 0;
    tx_data = d; tx_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 1; i <= 111; i++) begin
      exp_oe  = (i <= 100);
      exp_rdy = (i == 111);
      exp_o   = (i <= 100) ? frame_bit(d, (i-1)/10) : 1'b1;
      if (serial_oe === 1'b1) oe_cycles++;
      checks++; if (serial_oe !== exp_oe) $display("FAIL hd_oe cycle %0d got %b exp %b", i, serial_oe, exp_oe); else passed++;
      checks++; if (tx_ready !== exp_rdy) $display("FAIL hd_ready cycle %0d got %b exp %b", i, tx_ready, exp_rdy); else passed++;
      checks++; if (serial_o !== exp_o) $display("FAIL hd_bit cycle %0d got %b exp %b", i, serial_o, exp_o); else passed++;
      if (i < 111) tick();
    end
    repeat (20) tick();
    checks++; if (oe_cycles !== 100) $display("FAIL hd_oe_len got %0d exp 100", oe_cycles); else passed++;
    checks++; if (rxv_cnt - base !== 0) $display("FAIL hd_echo_valid got %0d exp 0", rxv_cnt - base); else passed++;
    checks++; if (ferr_cnt - fbase !== 0) $display("FAIL hd_echo_ferr got %0d exp 0", ferr_cnt - fbase); else passed++;
    loop_en = 1'b0;
    $display("tx 0x%02h half duplex done, echo suppressed", d);
  endtask

  task automatic test_hd_rx_block();
    logic got;
    got = 1'b0;
    tx_data = 8'h99;
    fork
      send_frame(8'h27, 1'b1, 0);
      begin
        repeat (20) tick();
        tx_valid = 1'b1;
        for (int i = 0; i < 150 && !got; i++) begin
          if (rx_valid === 1'b1) begin
            got = 1'b1;
            checks++; if (tx_ready !== 1'b1) $display("FAIL hd_block_release got %b exp 1", tx_ready); else passed++;
          end else begin
            checks++; if (tx_ready !== 1'b0) $display("FAIL hd_block_ready iter %0d got %b exp 0", i, tx_ready); else passed++;
            tick();
          end
        end
        checks++; if (got !== 1'b1) $display("FAIL hd_block_timeout got %b exp 1", got); else passed++;
        @(posedge clk); @(negedge clk);
        tx_valid = 1'b0;
        checks++; if (serial_o !== 1'b0) $display("FAIL hd_block_start got %b exp 0", serial_o); else passed++;
        checks++; if (serial_oe !== 1'b1) $display("FAIL hd_block_oe got %b exp 1", serial_oe); else passed++;
      end
    join
    checks++; if (rx_data !== 8'h27) $display("FAIL hd_block_rxdata got %02h exp 27", rx_data); else passed++;
    repeat (115) tick();
    $display("half duplex: tx 0x99 deferred until rx 0x27 completed");
  endtask

  task automatic test_mode_toggle();
    half_duplex_en = 1'b0;
    repeat (3) tick();
    checks++; if (serial_oe !== 1'b1) $display("FAIL toggle_fd_oe got %b exp 1", serial_oe); else passed++;
    tx_data = 8'h0F; tx_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 1; i <= 101; i++) begin
      if (i == 30) half_duplex_en = 1'b1;
      if (i <= 100) begin
        checks++; if (serial_oe !== 1'b1) $display("FAIL toggle_oe cycle %0d got %b exp 1", i, serial_oe); else passed++;
        tick();
      end else begin
        checks++; if (tx_ready !== 1'b1) $display("FAIL toggle_no_guard got %b exp 1", tx_ready); else passed++;
      end
    end
    tick(); tick();
    checks++; if (serial_oe !== 1'b0) $display("FAIL toggle_latched_oe got %b exp 0", serial_oe); else passed++;
    half_duplex_en = 1'b0;
    repeat (3) tick();
    $display("mode toggle mid-frame deferred to idle");
  endtask

  task automatic test_back_to_back();
    logic exp_o;
    tx_data = 8'hC3; tx_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    tx_data = 8'h3A;
    for (int i = 1; i <= 202; i++) begin
      if (i <= 100) exp_o = frame_bit(8'hC3, (i-1)/10);
      else if (i == 101 || i == 202) exp_o = 1'b1;
      else exp_o = frame_bit(8'h3A, (i-102)/10);
      checks++; if (serial_o !== exp_o) $display("FAIL b2b_bit cycle %0d got %b exp %b", i, serial_o, exp_o); else passed++;
      if (i == 101 || i == 202) begin
        checks++; if (tx_ready !== 1'b1) $display("FAIL b2b_ready cycle %0d got %b exp 1", i, tx_ready); else passed++;
      end
      if (i == 102) tx_valid = 1'b0;
      if (i < 202) tick();
    end
    $display("tx 0xc3,0x3a back to back done");
  endtask

  task automatic test_reset_midframe();
    int base, fbase;
    base = rxv_cnt; fbase = ferr_cnt;
    tx_data = 8'h66; tx_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    tx_valid = 1'b0;
    repeat (34) tick();
    checks++; if (serial_o !== 1'b1) $display("FAIL midframe_pre_bit got %b exp 1", serial_o); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (serial_o !== 1'b1) $display("FAIL midframe_rst_o got %b exp 1", serial_o); else passed++;
    checks++; if (serial_oe !== 1'b0) $display("FAIL midframe_rst_oe got %b exp 0", serial_oe); else passed++;
    checks++; if (tx_ready !== 1'b1) $display("FAIL midframe_rst_ready got %b exp 1", tx_ready); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) tick();
    checks++; if (rxv_cnt - base !== 0) $display("FAIL midframe_valid got %0d exp 0", rxv_cnt - base); else passed++;
    checks++; if (ferr_cnt - fbase !== 0) $display("FAIL midframe_ferr got %0d exp 0", ferr_cnt - fbase); else passed++;
    $display("reset mid-frame: line idle, no strobe");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_tx_fd(8'hA5);
    test_rx_good(8'h3C);
    test_frame_err();
    test_glitch();
    test_hd_tx(8'h81);
    test_hd_rx_block();
    test_mode_toggle();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
